// File: rtl/reconfig_result_accum_pkg.sv
// Shared types for the reconfigurable datapath result collector.
package reconfig_pkg;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_t;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } accum_state_t;
endpackage

// File: rtl/reconfig_result_accum_if.sv
// Sample input and summary-record output handshakes of the result collector.
interface reconfig_result_accum_if #(
  parameter int ACC_W = 16,
  parameter int WIN   = 16
);
  import reconfig_pkg::*;
  localparam int CNT_W = $clog2(WIN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [Y_W-1:0]   in_y;
  logic             in_s0;
  logic             in_s1;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_mode;
  logic [ACC_W-1:0] out_sum;
  logic [Y_W-1:0]   out_max;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_y, in_s0, in_s1, out_ready,
    input  in_ready, out_valid, out_mode, out_sum, out_max, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_y, in_s0, in_s1, out_ready,
    output in_ready, out_valid, out_mode, out_sum, out_max, out_cnt, out_ovf
  );
endinterface

// File: rtl/reconfig_result_accum_accum_cell.sv
// Per-mode statistics registers: sum, sample count, maximum and sticky overflow.
// Sum saturates when RECONFIG_ACCUM_SAT_EN is defined, otherwise wraps.
module reconfig_accum_cell
  import reconfig_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add,
  input  logic [Y_W-1:0]   y,
  output logic [ACC_W-1:0] sum,
  output logic [Y_W-1:0]   max_y,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_nxt;

  assign sum_ext = {1'b0, sum} + {{(ACC_W + 1 - Y_W){1'b0}}, y};

`ifdef RECONFIG_ACCUM_SAT_EN
  assign sum_nxt = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
  assign sum_nxt = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      max_y <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      sum   <= '0;
      max_y <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (add) begin
      sum <= sum_nxt;
      cnt <= cnt + CNT_W'(1);
      if (y > max_y) max_y <= y;
      // carry of the unclamped add flags overflow in both builds
      if (sum_ext[ACC_W]) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/reconfig_result_accum.sv
// Windowed per-topology result collector; drains four summary records per window.
// Build option: RECONFIG_ACCUM_SAT_EN selects saturating sums (default wraps).
//
// state | meaning
// ACCUM | taking samples until WIN have been accepted
// DRAIN | presenting record[idx], idx 0..3, one per handshake
module reconfig_result_accum
  import reconfig_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int WIN   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  reconfig_result_accum_if.slave  bus
);
  localparam int CNT_W = $clog2(WIN + 1);
  localparam logic [0:0] ST_ACCUM = 1'(ACCUM);
  localparam logic [0:0] ST_DRAIN = 1'(DRAIN);

  logic [0:0]       state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] win_cnt;
  logic             accept;
  logic             take;
  logic             drain_done;
  logic             cell_clr;
  logic [3:0]       cell_add;
  logic [1:0]       in_mode;

  logic [ACC_W-1:0] sum_a [4];
  logic [Y_W-1:0]   max_a [4];
  logic [CNT_W-1:0] cnt_a [4];
  logic [3:0]       ovf_a;

  assign in_mode      = {bus.in_s1, bus.in_s0};
  assign bus.in_ready  = (state == ST_ACCUM);
  assign bus.out_valid = (state == ST_DRAIN);

  // clr wins over both a sample and a record handshake in the same cycle
  assign accept     = bus.in_valid && bus.in_ready && !clr;
  assign take       = bus.out_valid && bus.out_ready && !clr;
  assign drain_done = take && (idx == 2'd3);
  assign cell_clr   = clr || drain_done;

  always_comb begin
    cell_add = '0;
    if (accept) cell_add[in_mode] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACCUM;
      idx     <= '0;
      win_cnt <= '0;
    end else if (clr) begin
      state   <= ST_ACCUM;
      idx     <= '0;
      win_cnt <= '0;
    end else if (state == ST_ACCUM) begin
      if (accept) begin
        win_cnt <= win_cnt + CNT_W'(1);
        if (win_cnt == CNT_W'(WIN - 1)) begin
          state <= ST_DRAIN;
          idx   <= '0;
        end
      end
    end else begin
      if (take) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          state   <= ST_ACCUM;
          win_cnt <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cell
    reconfig_accum_cell #(
      .ACC_W(ACC_W),
      .CNT_W(CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cell_clr),
      .add   (cell_add[g]),
      .y     (bus.in_y),
      .sum   (sum_a[g]),
      .max_y (max_a[g]),
      .cnt   (cnt_a[g]),
      .ovf   (ovf_a[g])
    );
  end

  // record fields read as zero outside DRAIN so the idle bus is quiet
  assign bus.out_mode = idx;
  assign bus.out_sum  = bus.out_valid ? sum_a[idx] : '0;
  assign bus.out_max  = bus.out_valid ? max_a[idx] : '0;
  assign bus.out_cnt  = bus.out_valid ? cnt_a[idx] : '0;
  assign bus.out_ovf  = bus.out_valid ? ovf_a[idx] : 1'b0;
endmodule

// File: tb/tb_reconfig_result_accum.sv
// Directed + randomized bench for reconfig_result_accum against a window-level model.
module tb_reconfig_result_accum;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  reconfig_result_accum_if #(.ACC_W(16), .WIN(16)) bus_a ();
  reconfig_result_accum_if #(.ACC_W(10), .WIN(4))  bus_b ();

  reconfig_result_accum #(.ACC_W(16), .WIN(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_a)
  );
  reconfig_result_accum #(.ACC_W(10), .WIN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_b)
  );

  int n_err = 0;
  int n_chk = 0;
  int sel   = 0;
  int acc_w = 16;
  int win   = 16;

  longint m_sum [4];
  int     m_cnt [4];
  int     m_max [4];

  logic        r_in_ready, r_out_valid, r_ovf;
  logic [1:0]  r_mode;
  logic [15:0] r_sum;
  logic [8:0]  r_max;
  logic [4:0]  r_cnt;

  always_comb begin
    if (sel == 0) begin
      r_in_ready  = bus_a.in_ready;
      r_out_valid = bus_a.out_valid;
      r_mode      = bus_a.out_mode;
      r_sum       = bus_a.out_sum;
      r_max       = bus_a.out_max;
      r_cnt       = bus_a.out_cnt;
      r_ovf       = bus_a.out_ovf;
    end else begin
      r_in_ready  = bus_b.in_ready;
      r_out_valid = bus_b.out_valid;
      r_mode      = bus_b.out_mode;
      r_sum       = 16'(bus_b.out_sum);
      r_max       = bus_b.out_max;
      r_cnt       = 5'(bus_b.out_cnt);
      r_ovf       = bus_b.out_ovf;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int y, input int m, input logic r);
    if (sel == 0) begin
      bus_a.in_valid = v; bus_a.in_y = 9'(y);
      bus_a.in_s0 = m[0]; bus_a.in_s1 = m[1]; bus_a.out_ready = r;
    end else begin
      bus_b.in_valid = v; bus_b.in_y = 9'(y);
      bus_b.in_s0 = m[0]; bus_b.in_s1 = m[1]; bus_b.out_ready = r;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_max[i] = 0;
    end
  endtask

  function automatic longint lim();
    return (longint'(1) << acc_w) - 1;
  endfunction

  function automatic longint exp_sum(input longint total);
`ifdef RECONFIG_ACCUM_SAT_EN
    return (total > lim()) ? lim() : total;
`else
    return total % (lim() + 1);
`endif
  endfunction

  // one accepted sample; starts and ends on a falling edge
  task automatic send(input int y, input int m);
    chk("send.in_ready", r_in_ready, 1'b1);
    drive(1'b1, y, m, 1'b0);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    m_sum[m] += y;
    m_cnt[m] += 1;
    if (y > m_max[m]) m_max[m] = y;
  endtask

  task automatic check_rec(input int i);
    chk($sformatf("rec%0d.valid", i), r_out_valid, 1'b1);
    chk($sformatf("rec%0d.in_ready", i), r_in_ready, 1'b0);
    chk($sformatf("rec%0d.mode", i), r_mode, i);
    chk($sformatf("rec%0d.sum", i), r_sum, exp_sum(m_sum[i]));
    chk($sformatf("rec%0d.max", i), r_max, m_max[i]);
    chk($sformatf("rec%0d.cnt", i), r_cnt, m_cnt[i]);
    chk($sformatf("rec%0d.ovf", i), r_ovf, m_sum[i] > lim());
  endtask

  // drain all four records, stalling bp_len cycles on record bp_idx with junk samples offered
  task automatic drain(input int bp_idx, input int bp_len);
    for (int i = 0; i < 4; i++) begin
      check_rec(i);
      if (i == bp_idx) begin
        for (int k = 0; k < bp_len; k++) begin
          drive(1'b1, $urandom_range(0, 511), $urandom_range(0, 3), 1'b0);
          @(negedge clk);
          check_rec(i);
        end
      end
      drive(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      drive(1'b0, 0, 0, 1'b0);
    end
    chk("drain.end_valid", r_out_valid, 1'b0);
    chk("drain.end_in_ready", r_in_ready, 1'b1);
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".in_ready"}, r_in_ready, 1'b1);
    chk({tag, ".out_valid"}, r_out_valid, 1'b0);
    chk({tag, ".mode"}, r_mode, 0);
    chk({tag, ".sum"}, r_sum, 0);
    chk({tag, ".max"}, r_max, 0);
    chk({tag, ".cnt"}, r_cnt, 0);
    chk({tag, ".ovf"}, r_ovf, 1'b0);
  endtask

  task automatic random_window();
    for (int k = 0; k < win; k++) send($urandom_range(0, 511), $urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ys [4];
    ys = '{303, 64, 304, 65};
    model_clear();
    sel = 1; drive(1'b0, 0, 0, 1'b0);
    sel = 0; drive(1'b0, 0, 0, 1'b0);

    #1 rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-window after 5 samples, then a full fresh window
    for (int k = 0; k < 5; k++) send($urandom_range(0, 511), $urandom_range(0, 3));
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_win");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    for (int k = 0; k < 15; k++) send($urandom_range(0, 511), $urandom_range(0, 3));
    chk("rst_fresh.not_early", r_out_valid, 1'b0);
    send($urandom_range(0, 511), $urandom_range(0, 3));
    drain(-1, 0);

    // reset mid-drain after record 0 was consumed
    random_window();
    check_rec(0);
    drive(1'b0, 0, 0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_drain");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);

    // single mode
    for (int k = 0; k < 16; k++) send(303, 0);
    chk("single.sum_value", r_sum, 4848);
    drain(-1, 0);

    // mixed modes with backpressure on record 1
    for (int k = 0; k < 16; k++) send(ys[k % 4], k % 4);
    drain(1, 10);

    // clr together with sample 8
    for (int k = 0; k < 7; k++) send($urandom_range(0, 511), $urandom_range(0, 3));
    drive(1'b1, 100, 1, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    model_clear();
    check_zero("clr_accum");
    for (int k = 0; k < 15; k++) send($urandom_range(0, 511), $urandom_range(0, 3));
    chk("clr.not_early", r_out_valid, 1'b0);
    send($urandom_range(0, 511), $urandom_range(0, 3));
    drain(0, 2);

    // clr beats a record handshake
    random_window();
    check_rec(0);
    drive(1'b0, 0, 0, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    model_clear();
    check_zero("clr_drain");

    // randomized windows with random stalls
    for (int w = 0; w < 4; w++) begin
      random_window();
      drain($urandom_range(0, 3), $urandom_range(0, 3));
    end

    // narrow sums, WIN=4: overflow on mode 2
    sel = 1; acc_w = 10; win = 4;
    model_clear();
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(511, 2);
`ifdef RECONFIG_ACCUM_SAT_EN
    chk("ovf.sum_pre", m_sum[2] == 2044, 1'b1);
`endif
    drain(-1, 0);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) send($urandom_range(200, 511), $urandom_range(0, 3));
      drain($urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/reconfig_result_accum.md
# reconfig_result_accum

Downstream collector for the reconfigurable multi-topology datapath. Each accepted sample pairs the 9-bit datapath result `y` with the `{s1,s0}` topology select that produced it. The block accumulates per-topology statistics over a fixed window of samples: sum, maximum, count and an overflow flag. At the end of each window it drains four summary records, one per mode, over a valid/ready handshake.

## Interface
- `ACC_W`, default 16: per-mode sum width; must be ≥ 10.
- `WIN`, default 16: accepted samples per window; must be ≥ 1.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `clr`, in, 1: synchronous window abort/clear.
- `in_valid`, in, 1: sample present.
- `in_ready`, out, 1: block accepts a sample.
- `in_y`, in, 9: datapath result, unsigned.
- `in_s0`, in, 1: topology select bit 0 at the time of the sample.
- `in_s1`, in, 1: topology select bit 1 at the time of the sample.
- `out_valid`, out, 1: summary record present.
- `out_ready`, in, 1: consumer takes the record.
- `out_mode`, out, 2: mode `{s1,s0}` of the record.
- `out_sum`, out, `ACC_W`: sum of `y` for that mode.
- `out_max`, out, 9: largest `y` seen for that mode; 0 if no samples.
- `out_cnt`, out, `$clog2(WIN+1)`: samples of that mode in the window.
- `out_ovf`, out, 1: sum exceeded `2^ACC_W-1` at least once in the window.

## Operation
- FSM with two states, `ACCUM` and `DRAIN`. Reset state is `ACCUM`.
- **ACCUM**
  - `in_ready`=1.
  - A sample is accepted when `in_valid && in_ready`.
  - On acceptance, mode m=`{in_s1,in_s0}`:
    - sum[m] += zero-extended `in_y`;
    - cnt[m]++;
    - max[m] = max(max[m], `in_y`);
    - the window counter increments.
  - On the accepting edge where the window counter reaches `WIN`, the state moves to `DRAIN` with drain index 0.
- **DRAIN**
  - `in_ready`=0 and `out_valid`=1.
  - Outputs present record[idx], with `out_mode`=idx.
  - When `out_valid && out_ready`, idx advances.
  - On the handshake for idx=3, all accumulators, counts, maxima, flags and the window counter clear, and the state returns to `ACCUM`.
- **Overflow**
  - When the carry out of sum[m] is set, ovf[m] is set (sticky until the window clears).
  - Sum behaviour on overflow is set by the configuration macro.
- **clr**
  - Zeroes all per-mode state, the window counter and idx. Forces `ACCUM` and drops `out_valid` on the next edge.
  - Has priority over a simultaneous sample (the sample is discarded) and over a simultaneous output handshake (the record counts as not consumed).
- **Reset**: async assertion at any point, including mid-window or mid-drain, immediately clears everything.
  - `in_ready`=1 (in `ACCUM`) and `out_valid`=0.
  - `out_mode`, `out_sum`, `out_max`, `out_cnt` and `out_ovf` are all 0.

## Timing
- Accumulation latency is 1 cycle: a sample accepted at edge k is visible in the record contents from edge k.
- `out_valid` rises the cycle after the WIN-th acceptance.
- `in_ready` falls in that same cycle, with no combinational path from `in_valid`.
- Back-to-back acceptance is allowed every cycle in `ACCUM`, so window throughput is WIN + 4 cycles minimum.
- Record fields are registered and held stable while `out_valid && !out_ready`.
- `in_ready` depends only on state. `out_valid` depends only on state.
- WIN=1: one sample, then drain.
- A mode with zero samples still drains a record with cnt=0, sum=0, max=0, ovf=0.

## Configuration
- `RECONFIG_ACCUM_SAT_EN` defined: sum[m] clamps at `2^ACC_W-1` on overflow.
- Undefined: sum[m] wraps modulo `2^ACC_W`.
- `out_ovf` behaves identically in both builds.

## Structure
- Shared package `reconfig_pkg`:
  - `mode_t` (2-bit, `MODE_0`..`MODE_3` for `{s1,s0}`);
  - `accum_state_t` (`ACCUM`, `DRAIN`);
  - `Y_W`=9.
- One sub-module, `reconfig_accum_cell`: per-mode sum/cnt/max/ovf registers with add and clear ports. It is instantiated 4×.
- The top level holds the FSM, the window counter and the drain mux.

## Test plan
- **Reset**: assert `rst_n`=0 mid-window after 5 samples → all outputs 0 and `in_ready`=1. A fresh window then starts at count 0.
- **Single mode**: WIN=16, 16 samples of y=303 in mode 0 → record 0 is sum=4848, max=303, cnt=16, ovf=0. Records 1–3 are all zero.
- **Mixed modes**: 4 samples each of y = 303, 64, 304, 65 in modes 0–3 → each record has sum = 4×y and cnt=4. Modes drain in order 0,1,2,3.
- **Backpressure**: hold `out_ready`=0 for 10 cycles during drain → the record is stable, `in_ready`=0, and `in_valid` samples are ignored.
- **Overflow**: ACC_W=10, 4 samples of y=511 in mode 2 → ovf=1. Sum is 1023 with the macro and 2044 mod 1024 = 1020 without it.
- **clr**: assert `clr` together with `in_valid` on sample 8 → the sample is dropped. The next window needs 16 fresh samples before draining.
